// File: rtl/qspi_mem_model.sv
// qspi_mem_model: clocked multi-chip quad-SPI memory model.
// The QSPI clock from the design is sampled and edge-detected in the clk domain.
// Command and address are decoded, then the model either serves quad reads after
// a runtime-selectable number of dummy clocks or accepts quad writes on banks
// marked writable. Protocol errors raise a one-cycle pulse and a sticky code.
// Ports:
//   i_clk, i_rst        system clock, synchronous active-high reset
//   i_qspi_clk          design QSPI clock (sampled only)
//   i_qspi_cs_n         per-bank chip selects, active low
//   i_qspi_d_in         design-driven data nibble
//   i_dummy_cycles      dummy QSPI clocks before read data
//   o_qspi_d_out/_oe    model-driven data nibble and its enables
//   o_busy              high whenever the model is not idle
//   o_err_pulse/_code   error strobe; code 1 multi-CS, 2 bad opcode, 3 read-only write
module qspi_mem_model #(
  parameter int unsigned        NUM_CS        = 3,
  parameter int unsigned        ADDR_W        = 16,
  parameter logic [NUM_CS-1:0]  WRITABLE_MASK = 'b110,
  parameter int unsigned        MAX_DUMMY     = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_qspi_clk,
  input  logic [NUM_CS-1:0] i_qspi_cs_n,
  input  logic [3:0]        i_qspi_d_in,
  input  logic [3:0]        i_dummy_cycles,
  output logic [3:0]        o_qspi_d_out,
  output logic [3:0]        o_qspi_d_oe,
  output logic              o_busy,
  output logic              o_err_pulse,
  output logic [1:0]        o_err_code
);

  localparam int unsigned BANK_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam int unsigned SHIFT_W   = ADDR_W - 4;
  localparam logic [3:0]  DUMMY_MAX = (MAX_DUMMY > 15) ? 4'd15 : 4'(MAX_DUMMY);
  localparam logic [7:0]  OP_READ   = 8'h0B;
  localparam logic [7:0]  OP_WRITE  = 8'h02;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DUMMY  = 3'd3;
  localparam logic [2:0] S_READ   = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;
  localparam logic [2:0] S_IGNORE = 3'd6;

  logic [7:0]          r_mem [NUM_CS][DEPTH];

  logic [2:0]          r_state, w_state_nxt;
  logic                r_clk_q;
  logic [BANK_W-1:0]   r_bank;
  logic [2:0]          r_cnt;
  logic [SHIFT_W-1:0]  r_shift;
  logic                r_is_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_dummy_left;
  logic                r_rd_lo;
  logic                r_wr_have;
  logic [3:0]          r_wr_nib;
  logic                r_armed;
  logic [3:0]          r_d_out;
  logic [3:0]          r_oe;
  logic                r_busy;
  logic                r_err_pulse;
  logic [1:0]          r_err_code;

  logic                w_rise, w_fall;
  logic [2:0]          w_low_cnt;
  logic [BANK_W-1:0]   w_sel_idx;
  logic                w_multi, w_one, w_all_high, w_desel;
  logic [7:0]          w_opcode, w_rd_byte;
  logic [ADDR_W-1:0]   w_addr_in;
  logic [3:0]          w_dummy_sat;
  logic                w_err;
  logic [1:0]          w_err_code;
  logic                w_active, w_mem_we;

  assign w_rise      = i_qspi_clk & ~r_clk_q;
  assign w_fall      = ~i_qspi_clk & r_clk_q;
  assign w_opcode    = {r_shift[3:0], i_qspi_d_in};
  assign w_addr_in   = {r_shift, i_qspi_d_in};
  assign w_rd_byte   = r_mem[r_bank][r_addr];
  assign w_dummy_sat = (i_dummy_cycles > DUMMY_MAX) ? DUMMY_MAX : i_dummy_cycles;
  assign w_desel     = i_qspi_cs_n[r_bank];
  assign w_all_high  = &i_qspi_cs_n;
  assign w_multi     = (w_low_cnt > 3'd1);
  assign w_one       = (w_low_cnt == 3'd1);

  // Count asserted chip selects and remember which one is low
  always_comb begin
    w_low_cnt = 3'd0;
    w_sel_idx = '0;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (!i_qspi_cs_n[i]) begin
        w_low_cnt = w_low_cnt + 3'd1;
        w_sel_idx = BANK_W'(i);
      end
    end
  end

  // Next-state and error decode; multi-CS beats deselect beats clock edges
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_err_code  = 2'd0;
    if (w_multi && r_armed) begin
      w_state_nxt = S_IGNORE;
      w_err       = 1'b1;
      w_err_code  = 2'd1;
    end else begin
      case (r_state)
        S_IDLE:   if (r_armed && w_one) w_state_nxt = S_CMD;
        // r_armed low here means a multi-CS ignore: wait for every CS to rise
        S_IGNORE: if (r_armed ? w_desel : w_all_high) w_state_nxt = S_IDLE;
        default: begin
          if (w_desel) begin
            w_state_nxt = S_IDLE;
          end else begin
            case (r_state)
              S_CMD: begin
                if (w_rise && r_cnt == 3'd1) begin
                  if (w_opcode == OP_READ || w_opcode == OP_WRITE) begin
                    w_state_nxt = S_ADDR;
                  end else begin
                    w_state_nxt = S_IGNORE;
                    w_err       = 1'b1;
                    w_err_code  = 2'd2;
                  end
                end
              end
              S_ADDR: begin
                if (w_rise && r_cnt == 3'd5) begin
                  if (!r_is_write) begin
                    w_state_nxt = S_DUMMY;
                  end else if (WRITABLE_MASK[r_bank]) begin
                    w_state_nxt = S_WRITE;
                  end else begin
                    w_state_nxt = S_IGNORE;
                    w_err       = 1'b1;
                    w_err_code  = 2'd3;
                  end
                end
              end
              S_DUMMY: if (w_fall && r_dummy_left == 4'd0) w_state_nxt = S_READ;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign w_active = (r_state != S_IDLE) && (w_state_nxt != S_IDLE) && (w_state_nxt != S_IGNORE);
  assign w_mem_we = !i_rst && w_active && (r_state == S_WRITE) && w_rise && r_wr_have;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Datapath and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_q      <= 1'b0;
      r_bank       <= '0;
      r_cnt        <= 3'd0;
      r_shift      <= '0;
      r_is_write   <= 1'b0;
      r_addr       <= '0;
      r_dummy_left <= 4'd0;
      r_rd_lo      <= 1'b0;
      r_wr_have    <= 1'b0;
      r_wr_nib     <= 4'd0;
      r_armed      <= 1'b0;
      r_d_out      <= 4'd0;
      r_oe         <= 4'd0;
      r_busy       <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_code   <= 2'd0;
    end else begin
      r_clk_q     <= i_qspi_clk;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_err_pulse <= w_err;
      if (w_err) r_err_code <= w_err_code;
      // Disarmed by reset or multi-CS until the bus is fully released
      if (w_all_high)   r_armed <= 1'b1;
      else if (w_multi) r_armed <= 1'b0;
      if (r_state == S_IDLE && w_state_nxt == S_CMD) begin
        r_bank <= w_sel_idx;
        r_cnt  <= 3'd0;
      end
      if (!w_active) begin
        r_oe      <= 4'd0;
        r_d_out   <= 4'd0;
        r_wr_have <= 1'b0;
      end else begin
        case (r_state)
          S_CMD: begin
            if (w_rise) begin
              r_shift <= {r_shift[SHIFT_W-5:0], i_qspi_d_in};
              if (r_cnt == 3'd1) begin
                r_cnt      <= 3'd0;
                r_is_write <= (w_opcode == OP_WRITE);
              end else begin
                r_cnt <= r_cnt + 3'd1;
              end
            end
          end
          S_ADDR: begin
            if (w_rise) begin
              r_shift <= {r_shift[SHIFT_W-5:0], i_qspi_d_in};
              if (r_cnt == 3'd5) begin
                r_cnt        <= 3'd0;
                r_addr       <= w_addr_in;
                r_dummy_left <= w_dummy_sat;
                r_wr_have    <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 3'd1;
              end
            end
          end
          S_DUMMY: begin
            if (w_rise && r_dummy_left != 4'd0) r_dummy_left <= r_dummy_left - 4'd1;
            if (w_fall && r_dummy_left == 4'd0) begin
              r_oe    <= 4'hF;
              r_d_out <= w_rd_byte[7:4];
              r_rd_lo <= 1'b1;
            end
          end
          S_READ: begin
            if (w_fall) begin
              if (r_rd_lo) begin
                r_d_out <= w_rd_byte[3:0];
                r_addr  <= r_addr + ADDR_W'(1);
                r_rd_lo <= 1'b0;
              end else begin
                r_d_out <= w_rd_byte[7:4];
                r_rd_lo <= 1'b1;
              end
            end
          end
          S_WRITE: begin
            if (w_rise) begin
              if (r_wr_have) begin
                r_addr    <= r_addr + ADDR_W'(1);
                r_wr_have <= 1'b0;
              end else begin
                r_wr_nib  <= i_qspi_d_in;
                r_wr_have <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Memory array; contents survive reset
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[r_bank][r_addr] <= {r_wr_nib, i_qspi_d_in};
  end

  assign o_qspi_d_out = r_d_out;
  assign o_qspi_d_oe  = r_oe;
  assign o_busy       = r_busy;
  assign o_err_pulse  = r_err_pulse;
  assign o_err_code   = r_err_code;

endmodule
